// File: rtl/tile_row_shifter_bank_if.sv
// Row-fetch handshake between the tile fetcher (master) and the per-layer row FIFOs (slave).
// Layer n occupies slice n of every packed field.
interface tile_row_shifter_bank_if #(
    parameter int NUM_LAYERS    = 3,
    parameter int PIXEL_WIDTH   = 4,
    parameter int PALETTE_WIDTH = 8
) ();
    logic [NUM_LAYERS-1:0]               row_valid;
    logic [NUM_LAYERS-1:0]               row_ready;
    logic [NUM_LAYERS*8*PIXEL_WIDTH-1:0] row_gfx;
    logic [NUM_LAYERS*PALETTE_WIDTH-1:0] row_pal;
    logic [NUM_LAYERS-1:0]               row_flipx;

    modport master (output row_valid, row_gfx, row_pal, row_flipx, input row_ready);
    modport slave  (input row_valid, row_gfx, row_pal, row_flipx, output row_ready);
endinterface

// File: rtl/tile_row_shifter_bank.sv
// Multi-layer tile pixel back end: per-layer row FIFO, 16-dot shifter with fine-scroll tap
// and X-flip, and a programmable-priority transparent mixer producing one registered dot.
module tile_row_shifter_bank #(
    parameter int NUM_LAYERS    = 3,
    parameter int PIXEL_WIDTH   = 4,
    parameter int PALETTE_WIDTH = 8,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ce_pixel,
    input  logic                                  line_start,
    tile_row_shifter_bank_if.slave                row_if,
    input  logic [NUM_LAYERS*3-1:0]               tap,
    input  logic [NUM_LAYERS-1:0]                 layer_en,
    input  logic [NUM_LAYERS*3-1:0]               prio_sel,
    input  logic                                  clr_underrun,
    output logic [PALETTE_WIDTH+PIXEL_WIDTH-1:0]  dot_out,
    output logic [2:0]                            dot_layer,
    output logic                                  dot_opaque,
    output logic [NUM_LAYERS-1:0]                 underrun
);
    localparam int DW = PALETTE_WIDTH + PIXEL_WIDTH;
    localparam int GW = 8 * PIXEL_WIDTH;
    localparam int RW = 1 + PALETTE_WIDTH + GW;

    typedef logic [DW-1:0] slot_t;
    typedef logic [RW-1:0] entry_t;   // {flipx, palette, gfx}

    // Storage is always 4 deep so the 2-bit pointers index it exactly; only FIFO_DEPTH entries are used.
    entry_t     fifo_q   [NUM_LAYERS][4];
    entry_t     fifo_d   [NUM_LAYERS][4];
    logic [1:0] rd_ptr_q [NUM_LAYERS];
    logic [1:0] rd_ptr_d [NUM_LAYERS];
    logic [1:0] wr_ptr_q [NUM_LAYERS];
    logic [1:0] wr_ptr_d [NUM_LAYERS];
    logic [2:0] count_q  [NUM_LAYERS];
    logic [2:0] count_d  [NUM_LAYERS];
    slot_t      sh_q     [NUM_LAYERS][16];
    slot_t      sh_d     [NUM_LAYERS][16];
    slot_t      cand     [NUM_LAYERS];

    logic [2:0]            phase_q, phase_d;
    logic [NUM_LAYERS-1:0] underrun_q, underrun_d;
    logic [NUM_LAYERS-1:0] row_ready, opaque;
    slot_t                 dot_out_q, dot_out_d;
    logic [2:0]            dot_layer_q, dot_layer_d;
    logic                  dot_opaque_q, dot_opaque_d;
    logic                  flush, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign flush = ce_pixel & line_start;
    assign pop   = ce_pixel & ~line_start & (phase_q == 3'd7);

    always_comb begin
        for (int n = 0; n < NUM_LAYERS; n++) row_ready[n] = (count_q[n] < 3'(FIFO_DEPTH));
    end
    assign row_if.row_ready = row_ready;

    always_comb begin
        entry_t ent;
        logic   push;
        logic   popped;
        phase_d = phase_q;
        if (flush)         phase_d = 3'd0;
        else if (ce_pixel) phase_d = phase_q + 3'd1;
        underrun_d = clr_underrun ? '0 : underrun_q;
        for (int n = 0; n < NUM_LAYERS; n++) begin
            fifo_d[n]   = fifo_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            wr_ptr_d[n] = wr_ptr_q[n];
            sh_d[n]     = sh_q[n];
            ent         = '0;
            push        = row_if.row_valid[n] & row_ready[n] & ~flush;
            popped      = pop & (count_q[n] != 3'd0);
            // No bypass: an empty pop underruns even if a row is pushed on the same edge; set beats clear.
            if (pop && count_q[n] == 3'd0) underrun_d[n] = 1'b1;
            if (popped) begin
                ent         = fifo_q[n][rd_ptr_q[n]];
                rd_ptr_d[n] = ptr_inc(rd_ptr_q[n]);
            end
            if (push) begin
                fifo_d[n][wr_ptr_q[n]] = {row_if.row_flipx[n],
                                          row_if.row_pal[n*PALETTE_WIDTH +: PALETTE_WIDTH],
                                          row_if.row_gfx[n*GW +: GW]};
                wr_ptr_d[n] = ptr_inc(wr_ptr_q[n]);
            end
            count_d[n] = count_q[n] + {2'b00, push} - {2'b00, popped};
            if (ce_pixel) begin
                for (int i = 15; i > 0; i--) sh_d[n][i] = sh_q[n][i-1];
                sh_d[n][0] = '0;
                if (pop) begin
                    for (int i = 0; i < 8; i++) begin
                        if (ent[RW-1]) sh_d[n][7-i] = {ent[GW +: PALETTE_WIDTH], ent[i*PIXEL_WIDTH +: PIXEL_WIDTH]};
                        else           sh_d[n][i]   = {ent[GW +: PALETTE_WIDTH], ent[i*PIXEL_WIDTH +: PIXEL_WIDTH]};
                    end
                end
            end
            if (flush) begin
                rd_ptr_d[n] = 2'd0;
                wr_ptr_d[n] = 2'd0;
                count_d[n]  = 3'd0;
                for (int i = 0; i < 16; i++) sh_d[n][i] = '0;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_LAYERS; n++) begin
            cand[n]   = sh_q[n][4'd15 - {1'b0, tap[n*3 +: 3]}];
            opaque[n] = layer_en[n] & (cand[n][PIXEL_WIDTH-1:0] != '0);
        end
    end

    // Priority scan; out-of-range slot entries never match a layer and so act as transparent.
    always_comb begin
        logic found;
        found        = 1'b0;
        dot_out_d    = dot_out_q;
        dot_layer_d  = dot_layer_q;
        dot_opaque_d = dot_opaque_q;
        if (ce_pixel) begin
            dot_out_d    = '0;
            dot_layer_d  = prio_sel[(NUM_LAYERS-1)*3 +: 3];
            dot_opaque_d = 1'b0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                for (int j = 0; j < NUM_LAYERS; j++) begin
                    if (!found && prio_sel[k*3 +: 3] == 3'(j) && opaque[j]) begin
                        found        = 1'b1;
                        dot_out_d    = cand[j];
                        dot_layer_d  = 3'(j);
                        dot_opaque_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            underrun_q   <= '0;
            dot_out_q    <= '0;
            dot_layer_q  <= '0;
            dot_opaque_q <= 1'b0;
            for (int n = 0; n < NUM_LAYERS; n++) begin
                rd_ptr_q[n] <= '0;
                wr_ptr_q[n] <= '0;
                count_q[n]  <= '0;
                for (int d = 0; d < 4; d++)  fifo_q[n][d] <= '0;
                for (int i = 0; i < 16; i++) sh_q[n][i]   <= '0;
            end
        end else begin
            phase_q      <= phase_d;
            underrun_q   <= underrun_d;
            dot_out_q    <= dot_out_d;
            dot_layer_q  <= dot_layer_d;
            dot_opaque_q <= dot_opaque_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
            sh_q         <= sh_d;
        end
    end

    assign dot_out    = dot_out_q;
    assign dot_layer  = dot_layer_q;
    assign dot_opaque = dot_opaque_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_tile_row_shifter_bank.sv
// Scoreboard bench for tile_row_shifter_bank: each ce_pixel edge queues its expected dot,
// an independent monitor pops and compares after every ce_pixel edge.
module tb_tile_row_shifter_bank;
    localparam int NL = 3;
    localparam int PW = 4;
    localparam int PALW = 8;
    localparam int DW = PALW + PW;

    logic            clk = 1'b0;
    logic            reset, ce_pixel, line_start, clr_underrun;
    logic [NL*3-1:0] tap, prio_sel;
    logic [NL-1:0]   layer_en;
    logic [DW-1:0]   dot_out;
    logic [2:0]      dot_layer;
    logic            dot_opaque;
    logic [NL-1:0]   underrun;

    tile_row_shifter_bank_if #(.NUM_LAYERS(NL), .PIXEL_WIDTH(PW), .PALETTE_WIDTH(PALW)) rif ();

    tile_row_shifter_bank #(.NUM_LAYERS(NL), .PIXEL_WIDTH(PW), .PALETTE_WIDTH(PALW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .line_start(line_start), .row_if(rif),
        .tap(tap), .layer_en(layer_en), .prio_sel(prio_sel), .clr_underrun(clr_underrun),
        .dot_out(dot_out), .dot_layer(dot_layer), .dot_opaque(dot_opaque), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          chk;
        logic [DW-1:0] dot;
        logic [2:0]    lay;
        logic          opq;
        int            tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_fail = 0;
    int   tag_no = 0;
    logic c_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(posedge clk) begin
        if (!reset && ce_pixel) begin
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL dot_unexpected: got %h want no edge", dot_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) begin
                    n_vec++;
                    if ({dot_out, dot_layer, dot_opaque} !== {mon_e.dot, mon_e.lay, mon_e.opq}) begin
                        n_fail++;
                        $display("FAIL dot[%0d]: got out=%h layer=%0d opaque=%b want out=%h layer=%0d opaque=%b",
                                 mon_e.tag, dot_out, dot_layer, dot_opaque, mon_e.dot, mon_e.lay, mon_e.opq);
                    end
                end
            end
        end
    end

    task automatic ce_edge(input bit ls, input bit chk, input logic [DW-1:0] d, input logic [2:0] l, input logic o);
        exp_t e;
        @(negedge clk);
        ce_pixel   = 1'b1;
        line_start = ls;
        e.chk = chk; e.dot = d; e.lay = l; e.opq = o; e.tag = tag_no;
        exp_q.push_back(e);
        tag_no++;
        @(negedge clk);
        ce_pixel   = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic dot_t();
        ce_edge(1'b0, 1'b1, '0, prio_sel[8:6], 1'b0);
    endtask

    task automatic dot_o(input logic [DW-1:0] d, input logic [2:0] l);
        ce_edge(1'b0, 1'b1, d, l, 1'b1);
    endtask

    task automatic flush_edge();
        ce_edge(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic clr_pulse();
        @(negedge clk); clr_underrun = 1'b1;
        @(negedge clk); clr_underrun = 1'b0;
    endtask

    task automatic push_row(input int ly, input logic [31:0] gfx, input logic [7:0] pal, input logic fx);
        @(negedge clk);
        rif.row_valid[ly]          = 1'b1;
        rif.row_gfx[ly*32 +: 32]   = gfx;
        rif.row_pal[ly*8 +: 8]     = pal;
        rif.row_flipx[ly]          = fx;
        @(negedge clk);
        rif.row_valid[ly]          = 1'b0;
    endtask

    // Single layer-0 row: flush, push, pop on the 8th edge, first dot (9 - tap) edges later.
    task automatic row_test(input logic [2:0] tp, input logic fx, input logic [31:0] gfx, input logic [7:0] pal);
        int s;
        int idx;
        logic [3:0] px;
        tap = {6'd0, tp};
        flush_edge();
        push_row(0, gfx, pal, fx);
        for (int e = 1; e <= 24; e++) begin
            s  = (e - 8) - (9 - int'(tp));
            px = 4'h0;
            if (s >= 0 && s < 8) begin
                idx = fx ? s : 7 - s;
                px  = gfx[idx*4 +: 4];
            end
            if (px != 4'h0) dot_o({pal, px}, 3'd0);
            else            dot_t();
        end
    endtask

    task automatic underrun_test();
        clr_pulse();
        check("underrun_clr", underrun, 3'b000);
        flush_edge();
        repeat (7) dot_t();
        clr_underrun = 1'b1;
        dot_t();
        clr_underrun = 1'b0;
        check("underrun_set_wins", underrun, 3'b111);
        repeat (8) dot_t();
        flush_edge();
        check("underrun_kept_by_flush", underrun, 3'b111);
    endtask

    task automatic fifo_test();
        logic [31:0] rows [3];
        logic [7:0]  pals [3];
        int r;
        int s;
        logic [3:0] px;
        rows[0] = 32'h12345678; pals[0] = 8'hA1;
        rows[1] = 32'h9ABCDEF1; pals[1] = 8'hB2;
        rows[2] = 32'h21436587; pals[2] = 8'hC3;
        tap = '0;
        clr_pulse();
        flush_edge();
        push_row(0, rows[0], pals[0], 1'b0);
        check("ready_after_push1", rif.row_ready[0], 1'b1);
        push_row(0, rows[1], pals[1], 1'b0);
        check("ready_after_push2", rif.row_ready[0], 1'b0);
        @(negedge clk);
        rif.row_valid[0]     = 1'b1;
        rif.row_gfx[31:0]    = rows[2];
        rif.row_pal[7:0]     = pals[2];
        rif.row_flipx[0]     = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_while_full", rif.row_ready[0], 1'b0);
        c_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200 && !c_done; k++) begin
                    @(negedge clk);
                    if (rif.row_ready[0]) begin
                        @(posedge clk);
                        #1;
                        rif.row_valid[0] = 1'b0;
                        c_done = 1'b1;
                    end
                end
            end
        join_none
        for (int e = 1; e <= 48; e++) begin
            if (e >= 17 && e <= 40) begin
                r  = (e - 17) / 8;
                s  = (e - 17) % 8;
                px = rows[r][(7-s)*4 +: 4];
                dot_o({pals[r], px}, 3'd0);
            end else begin
                dot_t();
            end
        end
        check("held_row_accepted", c_done, 1'b1);
        check("underrun_after_drain", underrun[0], 1'b1);
    endtask

    task automatic prio_test();
        clr_pulse();
        layer_en = 3'b111;
        tap      = '0;
        flush_edge();
        push_row(0, 32'h11111111, 8'h10, 1'b0);
        push_row(1, 32'h22222222, 8'h20, 1'b0);
        push_row(2, 32'h33333333, 8'h30, 1'b0);
        prio_sel = {3'd0, 3'd1, 3'd2};
        repeat (16) dot_t();
        dot_o(12'h303, 3'd2);
        dot_o(12'h303, 3'd2);
        prio_sel = {3'd2, 3'd1, 3'd0};
        dot_o(12'h101, 3'd0);
        dot_o(12'h101, 3'd0);
        layer_en = 3'b110;
        dot_o(12'h202, 3'd1);
        layer_en = 3'b000;
        dot_t();
        layer_en = 3'b111;
        prio_sel = {3'd1, 3'd7, 3'd5};
        dot_o(12'h202, 3'd1);
        prio_sel = {3'd2, 3'd1, 3'd0};
        dot_o(12'h101, 3'd0);
        dot_t();
    endtask

    task automatic flush_test();
        layer_en = 3'b001;
        tap      = '0;
        flush_edge();
        push_row(0, 32'h76543210, 8'h5A, 1'b0);
        repeat (16) dot_t();
        dot_o(12'h5A7, 3'd0);
        clr_pulse();
        check("underrun_pre_flush", underrun, 3'b000);
        push_row(0, 32'hAAAAAAAA, 8'h11, 1'b0);
        push_row(0, 32'hBBBBBBBB, 8'h22, 1'b0);
        check("ready_two_queued", rif.row_ready[0], 1'b0);
        dot_o(12'h5A6, 3'd0);
        dot_o(12'h5A5, 3'd0);
        ce_edge(1'b1, 1'b1, 12'h5A4, 3'd0, 1'b1);
        check("ready_after_flush", rif.row_ready, 3'b111);
        check("underrun_at_flush", underrun, 3'b000);
        repeat (7) dot_t();
        check("underrun_before_pop", underrun, 3'b000);
        dot_t();
        check("underrun_after_pop", underrun, 3'b111);
        repeat (8) dot_t();
    endtask

    task automatic reset_test();
        flush_edge();
        push_row(0, 32'h76543210, 8'h5A, 1'b0);
        repeat (16) dot_t();
        dot_o(12'h5A7, 3'd0);
        push_row(0, 32'h11111111, 8'h10, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_dot", {dot_out, dot_layer, dot_opaque}, '0);
        check("midreset_underrun", underrun, 3'b000);
        check("midreset_ready", rif.row_ready, 3'b111);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) dot_t();
        check("underrun_after_reset_pop", underrun, 3'b111);
    endtask

    initial begin
        reset         = 1'b1;
        ce_pixel      = 1'b0;
        line_start    = 1'b0;
        clr_underrun  = 1'b0;
        rif.row_valid = '0;
        rif.row_gfx   = '0;
        rif.row_pal   = '0;
        rif.row_flipx = '0;
        tap           = '0;
        layer_en      = 3'b001;
        prio_sel      = {3'd2, 3'd1, 3'd0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_dot_out", dot_out, '0);
        check("reset_dot_layer", dot_layer, 3'd0);
        check("reset_dot_opaque", dot_opaque, 1'b0);
        check("reset_underrun", underrun, 3'b000);
        check("reset_ready", rif.row_ready, 3'b111);

        row_test(3'd0, 1'b0, 32'h76543210, 8'h5A);
        check("underrun_no_row", underrun, 3'b111);
        row_test(3'd5, 1'b1, 32'h76543210, 8'h5A);
        row_test(3'd4, 1'b0, 32'h76543210, 8'h5A);
        row_test(3'd7, 1'b1, 32'h8ACE1357, 8'hC3);
        underrun_test();
        fifo_test();
        prio_test();
        flush_test();
        reset_test();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got still running want finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
